// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: word width, generator taps, seed and checker FSM encoding.
// Used by both the generator and the checker so the polynomial is defined in one place.
package lfsr_pkg;

  localparam int unsigned NUM_BITS = 16;
  localparam int unsigned CNT_BITS = 4;

  // Feedback taps of the 16-bit generator polynomial
  localparam int unsigned TAP_0 = 15;
  localparam int unsigned TAP_1 = 14;
  localparam int unsigned TAP_2 = 12;
  localparam int unsigned TAP_3 = 3;

  localparam logic [NUM_BITS-1:0] SEED = 16'h5EED;

  typedef logic [NUM_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_checker_if.sv
// Checker bus: received-word strobe and counter clear in, lock/error status out.
//   valid, word, clr_cnt           : master -> slave
//   locked, err_pulse, sync_loss,
//   err_count                      : slave -> master
interface lfsr_checker_if #(
  parameter int unsigned CNT_W = 16
);
  import lfsr_pkg::*;

  logic             valid;
  word_t            word;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic             sync_loss;
  logic [CNT_W-1:0] err_count;

  modport master (
    output valid, word, clr_cnt,
    input  locked, err_pulse, sync_loss, err_count
  );

  modport slave (
    input  valid, word, clr_cnt,
    output locked, err_pulse, sync_loss, err_count
  );

endinterface

// File: rtl/lfsr_step.sv
// One combinational advance of the 16-bit LFSR: shift left, feedback into bit 0.
//   word_i   : current word
//   step_c_o : next word in the sequence
module lfsr_step
  import lfsr_pkg::*;
(
  input  word_t word_i,
  output word_t step_c_o
);

  assign step_c_o = {word_i[NUM_BITS-2:0],
                     word_i[TAP_0] ^ word_i[TAP_1] ^ word_i[TAP_2] ^ word_i[TAP_3]};

endmodule

// File: rtl/lfsr_checker.sv
// LFSR stream checker: acquires lock on a received 16-bit sequence, then flywheels
// the expected value and counts mismatches, dropping lock after LOSS_CNT in a row.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of lfsr_checker_if (valid/word/clr_cnt in, status out)
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  lfsr_checker_if.slave bus
);

  state_e               state_q, state_d;
  word_t                exp_q, exp_d;
  logic [CNT_BITS-1:0]  good_q, good_d;
  logic [CNT_BITS-1:0]  bad_q, bad_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 sync_loss_q, sync_loss_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;

  word_t                step_in_c;
  word_t                step_c;
  logic [CNT_BITS-1:0]  good_inc_c;
  logic [CNT_BITS-1:0]  bad_inc_c;
  logic                 miss_c;
  logic [CNT_W-1:0]     cnt_base_c;

  // Once locked the prediction free-runs from the expected value; otherwise it
  // follows the received word (equal to expected on a VERIFY match).
  assign step_in_c  = (state_q == ST_LOCKED) ? exp_q : bus.word;
  assign good_inc_c = good_q + CNT_BITS'(1);
  assign bad_inc_c  = bad_q + CNT_BITS'(1);

  lfsr_step u_step (
    .word_i   (step_in_c),
    .step_c_o (step_c)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      exp_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_pulse_d = 1'b0;
    sync_loss_d = 1'b0;
    miss_c      = 1'b0;

    if (bus.valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (bus.word != '0) begin
            exp_d   = step_c;
            good_d  = '0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (bus.word == exp_q) begin
            exp_d  = step_c;
            good_d = good_inc_c;
            if (good_inc_c == CNT_BITS'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end
          end else if (bus.word != '0) begin
            exp_d  = step_c;
            good_d = '0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          exp_d = step_c;
          if (bus.word == exp_q) begin
            bad_d = '0;
          end else begin
            miss_c      = 1'b1;
            err_pulse_d = 1'b1;
            bad_d       = bad_inc_c;
            if (bad_inc_c == CNT_BITS'(LOSS_CNT)) begin
              state_d     = ST_SEARCH;
              sync_loss_d = 1'b1;
              bad_d       = '0;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // Clear first so a clear coinciding with a counted miss leaves exactly one
    cnt_base_c  = bus.clr_cnt ? '0 : err_count_q;
    err_count_d = cnt_base_c;
    if (miss_c && (cnt_base_c != {CNT_W{1'b1}})) begin
      err_count_d = cnt_base_c + CNT_W'(1);
    end

    locked_d = (state_d == ST_LOCKED);
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.sync_loss = sync_loss_q;
  assign bus.err_count = err_count_q;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive correct predictions required to declare lock (legal 1..15).
REQ-002 Parameter LOSS_CNT, default 3: consecutive mismatches while locked that declare sync loss (legal 1..15).
REQ-003 Parameter CNT_W, default 16: width of err_count.
REQ-004 clk  input  1  system clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 valid  input  1  one-cycle strobe; word is sampled on every cycle valid=1.
REQ-007 word  input  16  received LFSR word under test.
REQ-008 clr_cnt  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  high while the checker is in LOCKED.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatched word while LOCKED.
REQ-011 sync_loss  output  1  one-cycle pulse on the LOCKED->SEARCH transition.
REQ-012 err_count  output  CNT_W  saturating count of LOCKED mismatches.

Function
REQ-013 Prediction SHALL use step(w) = {w[14:0], w[15]^w[14]^w[12]^w[3]}, matching the team 16-bit generator polynomial.
REQ-014 FSM states SHALL be SEARCH, VERIFY, LOCKED; cycles with valid=0 SHALL change no state, counter or output except pulses returning low.
REQ-015 SEARCH, valid, word!=0: expected<=step(word), good_cnt<=0, ->VERIFY; word==0: stay SEARCH.
REQ-016 VERIFY, valid, word==expected: expected<=step(word), good_cnt++; when the increment reaches LOCK_CNT, ->LOCKED.
REQ-017 VERIFY, valid, mismatch, word!=0: reseed expected<=step(word), good_cnt<=0, stay VERIFY; mismatch with word==0: ->SEARCH.
REQ-018 LOCKED, valid, match: expected<=step(expected), bad_cnt<=0.
REQ-019 LOCKED, valid, mismatch: expected<=step(expected) (flywheel, no reseed), err_pulse=1 next cycle, err_count++ saturating at all-ones, bad_cnt++.
REQ-020 LOCKED, bad_cnt increment reaching LOSS_CNT: ->SEARCH, sync_loss=1 next cycle, locked=0 next cycle, bad_cnt<=0.
REQ-021 word==0 in LOCKED SHALL be treated as an ordinary mismatch.
REQ-022 All outputs SHALL be registered; latency from sampling valid to locked/err_pulse/sync_loss/err_count update is exactly 1 cycle.
REQ-023 A single non-consecutive mismatch SHALL NOT drop lock; a match clears bad_cnt.
REQ-024 clr_cnt SHALL zero err_count; clr_cnt concurrent with a counted mismatch SHALL yield err_count=1.
REQ-025 err_count SHALL persist across SEARCH/VERIFY and relock; only reset or clr_cnt clears it.

Reset
REQ-026 rst_n=0 at posedge clk: state=SEARCH, expected=0, good_cnt=0, bad_cnt=0, locked=0, err_pulse=0, sync_loss=0, err_count=0.
REQ-027 Reset mid-operation (any state) SHALL abandon lock immediately; the first valid after reset release is handled as in SEARCH.

Structure
REQ-028 Shared package lfsr_pkg SHALL hold NUM_BITS=16, tap positions {15,14,12,3}, SEED=16'h5EED and the FSM state encoding, shared with the generator.
REQ-029 Combinational sub-module lfsr_step (16-bit word in, step(word) out) SHALL be instantiated once for the prediction path.
REQ-030 Counters good_cnt/bad_cnt SHALL be 4 bits.

Verification
REQ-031 Feed 0x5EED, 0xBDDB, 0x7BB7, then 3 further correct steps on consecutive valids -> locked=1 one cycle after the 5th valid (1 seed + 4 matches).
REQ-032 Locked stream, corrupt one word (xor 0x0001) -> one err_pulse, err_count=1, locked stays 1, next correct word clears bad_cnt.
REQ-033 Locked stream, 3 consecutive corrupted words -> err_count=3, sync_loss pulse and locked=0 one cycle after the 3rd; correct stream relocks after 5 valids.
REQ-034 Feed 0x0000 repeatedly from reset -> state stays SEARCH, locked=0, err_count=0.
REQ-035 Force err_count to all-ones via mismatches (CNT_W=4) -> saturates at 15; clr_cnt with simultaneous mismatch -> 1.
REQ-036 Assert rst_n=0 while LOCKED with valid gaps of 0..5 idle cycles between words -> all outputs zero after reset; gaps never affect lock.
